instr_cycle_sequencer: RTL and testbench
========================================

// Module: instr_cycle_sequencer
// PURPOSE
//  Per-instruction timing sequencer for the E0C6S46 core. Sits between ROM fetch/decode and the
//  microcode executor: counts oscillator clocks for each instruction (5/7/12), strobes fetch and
//  decode, and emits the microcode_cycle/step pair the executor uses to drive reg_type transfers.
//  Also owns HALT sleep and interrupt-entry sequencing at instruction boundaries.
// PARAMETERS
//  INT_LENGTH  CYCLE12  instr_length used for the hardware interrupt-entry sequence
//  RESET_HALT  0        1 = leave reset in HALT state, waiting for an interrupt (bring-up aid)
// PORTS
//  clk               in   1            core clock
//  reset_n           in   1            asynchronous, active-low reset
//  clk_en            in   1            CPU clock enable; all state advances only when high
//  instr_len         in   instr_length decoder length; sampled on the decode cycle
//  halt_req          in   1            decoded HALT/SLP; sampled on the instr_done cycle
//  irq_pending       in   1            any unmasked interrupt factor pending
//  irq_enable        in   1            I flag
//  cycle_count       out  4            clock index within the current instruction, 0..len-1
//  fetch             out  1            ROM address/PC valid for fetch (cycle 0)
//  decode            out  1            opcode valid; decoder outputs sampled (cycle 1)
//  micro_cycle       out  microcode_cycle  NONE / REG_FETCH / REG_WRITE
//  micro_step        out  3            microcode step index, 0..4
//  instr_done        out  1            last clock of the instruction; PC advance/commit
//  interrupt_active  out  1            current sequence is interrupt entry (REG_STARTINTERRUPT)
//  halted            out  1            core asleep
// BEHAVIOUR
//  - Reset: state FETCH (HALT if RESET_HALT); cycle_count=0, latched len=CYCLE5.
//    Outputs: fetch=1 (0 if RESET_HALT), halted=RESET_HALT, all others 0/CYCLE_NONE.
//    An async reset mid-instruction discards the instruction.
//  - Outputs are a decode of registered state: no input-to-output combinational path, except
//    instr_done, which is a decode of cycle_count versus latched len.
//  - States: FETCH, DECODE, EXEC, HALT, INT. Transitions occur only on clk_en.
//  - Counter: FETCH sets cycle 0. DECODE sets cycle 1 and latches len = cycle_count_int(instr_len).
//    EXEC runs cycles 2..len-1.
//  - Micro cycle for c>=2: (c-2) even -> REG_FETCH, odd -> REG_WRITE; micro_step = (c-2)>>1.
//    Last cycle of odd-length instructions (5, 7) is CYCLE_NONE. Length 12 ends on REG_WRITE of
//    step 4.
//  - Boundary (instr_done at c=len-1), evaluated in priority order:
//    1. irq_pending & irq_enable -> INT. Counter restarts at 0, len=INT_LENGTH, no fetch/decode
//       strobes, interrupt_active=1 for the whole sequence.
//    2. halt_req -> HALT.
//    3. Otherwise -> FETCH.
//    The priority decision applies even when halt_req is high on the same clock.
//  - INT: micro_cycle/step follow the EXEC rule from c=0. instr_done at INT_LENGTH-1 -> FETCH
//    (nested interrupt not re-checked).
//  - HALT: halted=1, counter held at 0, micro_cycle NONE. irq_pending alone wakes, regardless of
//    irq_enable. With irq_enable=1 -> INT; with irq_enable=0 -> FETCH (resume after HALT).
//  - clk_en low: every register holds and outputs are stable. instr_done is not re-asserted
//    because no state changes.
//  - Illegal/unknown latched len: treated as CYCLE5.
// STRUCTURE
//  - Add enum seq_state {SEQ_FETCH, SEQ_DECODE, SEQ_EXEC, SEQ_HALT, SEQ_INT} to package types.
//  - Reuse instr_length, microcode_cycle and cycle_count_int from the package.
//  - No sub-module: one state register, a 4-bit counter, a latched 4-bit len and output decode.
// TESTING
//  1. clk_en=1, CYCLE5 -> fetch@0, decode@1, REG_FETCH s0@2, REG_WRITE s0@3, NONE+instr_done@4,
//     fetch@5.
//  2. CYCLE12 -> steps 0..4 alternate FETCH/WRITE on cycles 2..11; instr_done and REG_WRITE s4
//     on cycle 11.
//  3. CYCLE7 with irq_pending=1, irq_enable=1 raised at c=3 -> after c=6, INT for 12 cycles with
//     interrupt_active=1, then fetch.
//  4. halt_req at done -> halted=1 and counter frozen for 100 clocks; irq_pending=1, irq_enable=0
//     -> FETCH on the next clk_en.
//  5. clk_en toggling 1-of-4 -> identical output sequence to test 1, each step stretched 4 clocks.
//  6. reset_n low at EXEC c=5 of CYCLE12 -> outputs at reset values immediately (async); first
//     clk_en after release gives decode, no stale micro_cycle.

Source files
------------

// File: rtl/instr_cycle_sequencer_pkg.sv
// instr_cycle_sequencer_pkg
//   Shared types for the E0C6S46 instruction timing path:
//   - instr_length    : decoder-reported instruction length (5, 7 or 12 clocks)
//   - microcode_cycle : transfer phase handed to the microcode executor
//   - seq_state       : instruction sequencer states
//   - cycle_count_int : maps an instr_length to its clock count (unknown codes -> 5)
package instr_cycle_sequencer_pkg;

  typedef enum logic [1:0] {
    CYCLE5  = 2'd0,
    CYCLE7  = 2'd1,
    CYCLE12 = 2'd2
  } instr_length;

  typedef enum logic [1:0] {
    CYCLE_NONE      = 2'd0,
    CYCLE_REG_FETCH = 2'd1,
    CYCLE_REG_WRITE = 2'd2
  } microcode_cycle;

  typedef enum logic [2:0] {
    SEQ_FETCH  = 3'd0,
    SEQ_DECODE = 3'd1,
    SEQ_EXEC   = 3'd2,
    SEQ_HALT   = 3'd3,
    SEQ_INT    = 3'd4
  } seq_state;

  function automatic logic [3:0] cycle_count_int(input instr_length len);
    case (len)
      CYCLE7:  return 4'd7;
      CYCLE12: return 4'd12;
      default: return 4'd5;
    endcase
  endfunction

endpackage

// File: rtl/instr_cycle_sequencer.sv
// instr_cycle_sequencer
//   Per-instruction timing sequencer. Counts clocks within each instruction,
//   strobes fetch (cycle 0) and decode (cycle 1), and emits the microcode
//   cycle/step pair for cycles 2..len-1. Handles HALT sleep and interrupt
//   entry at instruction boundaries.
// Parameters
//   INT_LENGTH : length of the hardware interrupt-entry sequence
//   RESET_HALT : 1 = come out of reset asleep, waiting for an interrupt
// Ports
//   clk, reset_n (async, active-low), clk_en (all state advances only when high)
//   instr_len   : decoder length, sampled while in DECODE
//   halt_req    : HALT/SLP decoded, sampled on the instr_done cycle
//   irq_pending, irq_enable : interrupt request and I flag
//   cycle_count, fetch, decode, micro_cycle, micro_step, instr_done,
//   interrupt_active, halted : decodes of registered state
module instr_cycle_sequencer
  import instr_cycle_sequencer_pkg::*;
#(
  parameter instr_length INT_LENGTH = CYCLE12,
  parameter bit          RESET_HALT = 1'b0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clk_en,
  input  instr_length    instr_len,
  input  logic           halt_req,
  input  logic           irq_pending,
  input  logic           irq_enable,
  output logic [3:0]     cycle_count,
  output logic           fetch,
  output logic           decode,
  output microcode_cycle micro_cycle,
  output logic [2:0]     micro_step,
  output logic           instr_done,
  output logic           interrupt_active,
  output logic           halted
);

  localparam logic [3:0] INT_LEN_CLKS = cycle_count_int(INT_LENGTH);
  localparam seq_state   RESET_STATE  = RESET_HALT ? SEQ_HALT : SEQ_FETCH;

  seq_state   state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [3:0] len_q, len_d;

  logic [3:0] len_eff;
  logic       in_seq;
  logic       last_cycle;
  logic [3:0] ofs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_STATE;
      count_q <= 4'd0;
      len_q   <= 4'd5;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  // Any latched length other than 7 or 12 runs as a 5-clock instruction.
  always_comb begin
    len_eff    = ((len_q == 4'd7) || (len_q == 4'd12)) ? len_q : 4'd5;
    in_seq     = (state_q == SEQ_EXEC) || (state_q == SEQ_INT);
    last_cycle = in_seq && (count_q == (len_eff - 4'd1));
  end

  // Next-state: only clk_en moves anything.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    if (clk_en) begin
      case (state_q)
        SEQ_FETCH: begin
          state_d = SEQ_DECODE;
          count_d = 4'd1;
        end
        SEQ_DECODE: begin
          state_d = SEQ_EXEC;
          count_d = 4'd2;
          len_d   = cycle_count_int(instr_len);
        end
        SEQ_EXEC, SEQ_INT: begin
          if (last_cycle) begin
            count_d = 4'd0;
            // Interrupt entry beats HALT; the end of an interrupt sequence
            // always returns to FETCH without re-checking for another one.
            if ((state_q == SEQ_EXEC) && irq_pending && irq_enable) begin
              state_d = SEQ_INT;
              len_d   = INT_LEN_CLKS;
            end else if ((state_q == SEQ_EXEC) && halt_req) begin
              state_d = SEQ_HALT;
            end else begin
              state_d = SEQ_FETCH;
            end
          end else begin
            count_d = count_q + 4'd1;
          end
        end
        SEQ_HALT: begin
          count_d = 4'd0;
          // Any pending interrupt wakes the core; the I flag only decides
          // whether it is serviced or execution simply resumes.
          if (irq_pending) begin
            if (irq_enable) begin
              state_d = SEQ_INT;
              len_d   = INT_LEN_CLKS;
            end else begin
              state_d = SEQ_FETCH;
            end
          end
        end
        default: begin
          state_d = SEQ_FETCH;
          count_d = 4'd0;
        end
      endcase
    end
  end

  // Output decode. Microcode phases start at cycle 2 in both EXEC and INT,
  // so an interrupt sequence has two idle leading clocks in place of the
  // fetch/decode strobes. The final clock of odd-length sequences is idle.
  always_comb begin
    ofs              = count_q - 4'd2;
    cycle_count      = count_q;
    fetch            = (state_q == SEQ_FETCH);
    decode           = (state_q == SEQ_DECODE);
    instr_done       = last_cycle;
    interrupt_active = (state_q == SEQ_INT);
    halted           = (state_q == SEQ_HALT);
    micro_cycle      = CYCLE_NONE;
    micro_step       = 3'd0;
    if (in_seq && (count_q >= 4'd2) && !(last_cycle && len_eff[0])) begin
      micro_cycle = ofs[0] ? CYCLE_REG_WRITE : CYCLE_REG_FETCH;
      micro_step  = ofs[3:1];
    end
  end

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
module tb_instr_cycle_sequencer;
  import instr_cycle_sequencer_pkg::*;

  localparam instr_length TB_INT_LENGTH = CYCLE12;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           clk_en;
  instr_length    instr_len;
  logic           halt_req;
  logic           irq_pending;
  logic           irq_enable;
  logic [3:0]     cycle_count;
  logic           fetch;
  logic           decode;
  microcode_cycle micro_cycle;
  logic [2:0]     micro_step;
  logic           instr_done;
  logic           interrupt_active;
  logic           halted;

  instr_cycle_sequencer #(
    .INT_LENGTH (TB_INT_LENGTH),
    .RESET_HALT (1'b0)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .clk_en           (clk_en),
    .instr_len        (instr_len),
    .halt_req         (halt_req),
    .irq_pending      (irq_pending),
    .irq_enable       (irq_enable),
    .cycle_count      (cycle_count),
    .fetch            (fetch),
    .decode           (decode),
    .micro_cycle      (micro_cycle),
    .micro_step       (micro_step),
    .instr_done       (instr_done),
    .interrupt_active (interrupt_active),
    .halted           (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]     cc;
    logic           f;
    logic           d;
    microcode_cycle mc;
    logic [2:0]     ms;
    logic           done;
    logic           ia;
    logic           h;
  } out_t;

  typedef struct {
    logic        en;
    instr_length len;
    logic        hr;
    logic        ip;
    logic        ie;
    out_t        exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[$];

  // ---------------- reference model (instruction-level view) ----------------
  int m_pos;    // clock index inside the current sequence
  int m_len;    // clocks in the current sequence, 0 until known
  bit m_int;    // current sequence is interrupt entry
  bit m_sleep;  // core asleep

  function automatic int len_of(instr_length l);
    case (l)
      CYCLE7:  return 7;
      CYCLE12: return 12;
      default: return 5;
    endcase
  endfunction

  function automatic void model_reset();
    m_pos = 0; m_len = 0; m_int = 1'b0; m_sleep = 1'b0;
  endfunction

  function automatic bit m_done();
    return !m_sleep && (m_int || m_pos >= 2) && (m_pos == m_len - 1);
  endfunction

  function automatic out_t model_out();
    out_t o;
    int k;
    o = '0;
    o.mc = CYCLE_NONE;
    o.h = m_sleep;
    if (!m_sleep) begin
      o.cc   = 4'(m_pos);
      o.f    = !m_int && m_pos == 0;
      o.d    = !m_int && m_pos == 1;
      o.done = m_done();
      o.ia   = m_int;
      if (m_pos >= 2 && !(o.done && (m_len % 2 == 1))) begin
        k    = m_pos - 2;
        o.mc = (k % 2 == 1) ? CYCLE_REG_WRITE : CYCLE_REG_FETCH;
        o.ms = 3'(k / 2);
      end
    end
    return o;
  endfunction

  // Advance the model by one clock edge with the inputs present at that edge.
  task automatic model_step();
    if (!clk_en) return;
    if (m_sleep) begin
      if (irq_pending) begin
        m_sleep = 1'b0;
        m_pos   = 0;
        m_int   = irq_enable;
        m_len   = irq_enable ? len_of(TB_INT_LENGTH) : 0;
        $display("txn t=%0t wake %s", $time, irq_enable ? "to interrupt" : "to fetch");
      end
    end else if (m_done()) begin
      $display("txn t=%0t end of %s len=%0d", $time, m_int ? "interrupt entry" : "instruction", m_len);
      m_pos = 0;
      if (!m_int && irq_pending && irq_enable) begin
        m_int = 1'b1;
        m_len = len_of(TB_INT_LENGTH);
      end else if (!m_int && halt_req) begin
        m_sleep = 1'b1;
        m_int   = 1'b0;
      end else begin
        m_int = 1'b0;
        m_len = 0;
      end
    end else begin
      if (!m_int && m_pos == 1) m_len = len_of(instr_len);
      m_pos++;
    end
  endtask

  // ---------------- checking helpers ----------------
  function automatic out_t dut_out();
    out_t o;
    o.cc = cycle_count; o.f = fetch; o.d = decode; o.mc = micro_cycle;
    o.ms = micro_step; o.done = instr_done; o.ia = interrupt_active; o.h = halted;
    return o;
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf("c=%0d f=%b d=%b mc=%0d s=%0d done=%b int=%b halt=%b",
                     o.cc, o.f, o.d, o.mc, o.ms, o.done, o.ia, o.h);
  endfunction

  task automatic compare(string tag, out_t exp);
    out_t act;
    act = dut_out();
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t actual {%s} required {%s}", tag, $time, fmt(act), fmt(exp));
  endtask

  // Called in the low phase: check, cross one edge, return at the next negedge.
  task automatic step_check(string tag);
    compare(tag, model_out());
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  function automatic void add(logic en, instr_length l, logic ip, logic ie,
                              logic [3:0] cc, logic f, logic d, microcode_cycle mc,
                              logic [2:0] ms, logic dn, logic ia);
    vec_t v;
    v.en = en; v.len = l; v.hr = 1'b0; v.ip = ip; v.ie = ie;
    v.exp.cc = cc; v.exp.f = f; v.exp.d = d; v.exp.mc = mc; v.exp.ms = ms;
    v.exp.done = dn; v.exp.ia = ia; v.exp.h = 1'b0;
    vecs.push_back(v);
  endfunction

  localparam microcode_cycle NO = CYCLE_NONE;
  localparam microcode_cycle RF = CYCLE_REG_FETCH;
  localparam microcode_cycle RW = CYCLE_REG_WRITE;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t rst_exp;
    // Table: CYCLE5, then CYCLE12, then CYCLE7 interrupted into a 12-clock INT.
    //   en  len      ip ie  cc  f  d  mc  s  done int
    add(1, CYCLE5,  0, 0, 0,  1, 0, NO, 0, 0, 0);
    add(1, CYCLE5,  0, 0, 1,  0, 1, NO, 0, 0, 0);
    add(1, CYCLE5,  0, 0, 2,  0, 0, RF, 0, 0, 0);
    add(1, CYCLE5,  0, 0, 3,  0, 0, RW, 0, 0, 0);
    add(1, CYCLE5,  0, 0, 4,  0, 0, NO, 0, 1, 0);
    add(1, CYCLE5,  0, 0, 0,  1, 0, NO, 0, 0, 0);
    add(1, CYCLE12, 0, 0, 1,  0, 1, NO, 0, 0, 0);
    add(1, CYCLE5,  0, 0, 2,  0, 0, RF, 0, 0, 0);
    add(1, CYCLE5,  0, 0, 3,  0, 0, RW, 0, 0, 0);
    add(1, CYCLE5,  0, 0, 4,  0, 0, RF, 1, 0, 0);
    add(1, CYCLE5,  0, 0, 5,  0, 0, RW, 1, 0, 0);
    add(1, CYCLE5,  0, 0, 6,  0, 0, RF, 2, 0, 0);
    add(1, CYCLE5,  0, 0, 7,  0, 0, RW, 2, 0, 0);
    add(1, CYCLE5,  0, 0, 8,  0, 0, RF, 3, 0, 0);
    add(1, CYCLE5,  0, 0, 9,  0, 0, RW, 3, 0, 0);
    add(1, CYCLE5,  0, 0, 10, 0, 0, RF, 4, 0, 0);
    add(1, CYCLE5,  0, 0, 11, 0, 0, RW, 4, 1, 0);
    add(1, CYCLE5,  0, 0, 0,  1, 0, NO, 0, 0, 0);
    add(1, CYCLE7,  0, 0, 1,  0, 1, NO, 0, 0, 0);
    add(1, CYCLE5,  0, 0, 2,  0, 0, RF, 0, 0, 0);
    add(1, CYCLE5,  1, 1, 3,  0, 0, RW, 0, 0, 0);
    add(1, CYCLE5,  1, 1, 4,  0, 0, RF, 1, 0, 0);
    add(1, CYCLE5,  1, 1, 5,  0, 0, RW, 1, 0, 0);
    add(1, CYCLE5,  1, 1, 6,  0, 0, NO, 0, 1, 0);
    add(1, CYCLE5,  1, 1, 0,  0, 0, NO, 0, 0, 1);
    add(1, CYCLE5,  1, 1, 1,  0, 0, NO, 0, 0, 1);
    add(1, CYCLE5,  1, 1, 2,  0, 0, RF, 0, 0, 1);
    add(1, CYCLE5,  1, 1, 3,  0, 0, RW, 0, 0, 1);
    add(1, CYCLE5,  1, 1, 4,  0, 0, RF, 1, 0, 1);
    add(1, CYCLE5,  1, 1, 5,  0, 0, RW, 1, 0, 1);
    add(1, CYCLE5,  1, 1, 6,  0, 0, RF, 2, 0, 1);
    add(1, CYCLE5,  1, 1, 7,  0, 0, RW, 2, 0, 1);
    add(1, CYCLE5,  1, 1, 8,  0, 0, RF, 3, 0, 1);
    add(1, CYCLE5,  1, 1, 9,  0, 0, RW, 3, 0, 1);
    add(1, CYCLE5,  1, 1, 10, 0, 0, RF, 4, 0, 1);
    add(1, CYCLE5,  1, 1, 11, 0, 0, RW, 4, 1, 1);
    add(1, CYCLE5,  0, 0, 0,  1, 0, NO, 0, 0, 0);

    rst_exp = '0;
    rst_exp.f  = 1'b1;
    rst_exp.mc = CYCLE_NONE;

    clk_en = 1'b1; instr_len = CYCLE5; halt_req = 1'b0;
    irq_pending = 1'b0; irq_enable = 1'b0; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    compare("reset_state", rst_exp);
    reset_n = 1'b1;
    model_reset();

    // ---- table-driven vectors ----
    foreach (vecs[i]) begin
      clk_en = vecs[i].en; instr_len = vecs[i].len; halt_req = vecs[i].hr;
      irq_pending = vecs[i].ip; irq_enable = vecs[i].ie;
      compare($sformatf("vec%0d", i), vecs[i].exp);
      $display("txn vec%0d c=%0d", i, cycle_count);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    // ---- HALT at instr_done, 100 frozen clocks, then wake with I=0 ----
    instr_len = CYCLE5; halt_req = 1'b1; irq_pending = 1'b0; irq_enable = 1'b0;
    for (int i = 0; i < 12 && !m_sleep; i++) step_check("halt_entry");
    irq_enable = 1'b1;  // I flag alone must not wake the core
    for (int i = 0; i < 100; i++) step_check("halt_hold");
    irq_enable = 1'b0; irq_pending = 1'b1; clk_en = 1'b0;
    for (int i = 0; i < 2; i++) step_check("halt_no_clk_en");
    clk_en = 1'b1;
    step_check("halt_wake");
    irq_pending = 1'b0; halt_req = 1'b0;
    step_check("resume_fetch");

    // ---- interrupt beats a simultaneous HALT request ----
    instr_len = CYCLE7; halt_req = 1'b1; irq_pending = 1'b1; irq_enable = 1'b1;
    for (int i = 0; i < 30; i++) step_check("irq_vs_halt");
    halt_req = 1'b0; irq_pending = 1'b0; irq_enable = 1'b0;
    for (int i = 0; i < 14; i++) step_check("drain");

    // ---- clk_en one cycle in four ----
    for (int i = 0; i < 48; i++) begin
      clk_en = (i % 4 == 0);
      instr_len = CYCLE5;
      step_check("clk_en_1of4");
    end
    clk_en = 1'b1;

    // ---- unencoded length behaves as CYCLE5 ----
    instr_len = instr_length'(2'b11);
    for (int i = 0; i < 12; i++) step_check("illegal_len");

    // ---- async reset in the middle of a CYCLE12 EXEC ----
    instr_len = CYCLE12;
    for (int i = 0; i < 30 && !(m_pos == 5 && m_len == 12 && !m_int && !m_sleep); i++)
      step_check("pre_reset");
    compare("pre_reset_c5", model_out());
    reset_n = 1'b0;
    #1;
    compare("async_reset", rst_exp);
    @(negedge clk);
    compare("reset_held", rst_exp);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) step_check("post_reset");

    // ---- randomized stimulus against the model ----
    for (int i = 0; i < 3000; i++) begin
      clk_en      = ($urandom_range(0, 3) != 0);
      instr_len   = instr_length'($urandom_range(0, 3));
      halt_req    = ($urandom_range(0, 5) == 0);
      irq_pending = ($urandom_range(0, 7) == 0);
      irq_enable  = $urandom_range(0, 1) == 1;
      step_check("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
